snake_cmd_queue: RTL and testbench

- Parametrised successor to the keyboard command decoder.
- Accepts ASCII key strobes from the keyboard front-end and decodes them into direction, reset and start commands.
- Filters auto-repeat and buffers direction commands in a small FIFO, consumed one per game tick.
- Holds the registered snake heading, rejects 180° reversals, and tracks a WAIT/PLAY game state for the game-logic block.

---
 rtl/snake_cmd_pkg.sv | 29 ++
 rtl/cmd_fifo.sv | 60 ++++++
 rtl/snake_cmd_queue.sv | 149 ++++++++++++++
 tb/tb_snake_cmd_queue.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/snake_cmd_pkg.sv
// snake_cmd_pkg: heading encoding, FSM states and key codes for the snake command queue.
// Shared by cmd_fifo and snake_cmd_queue.
package snake_cmd_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic {
    ST_WAIT = 1'b0,
    ST_PLAY = 1'b1
  } state_t;

  localparam logic [7:0] KEY_UP    = 8'h77;
  localparam logic [7:0] KEY_DOWN  = 8'h73;
  localparam logic [7:0] KEY_LEFT  = 8'h61;
  localparam logic [7:0] KEY_RIGHT = 8'h64;
  localparam logic [7:0] KEY_RESET = 8'h72;
  localparam logic [7:0] KEY_START = 8'h71;

  // Opposite headings differ only in bit 0.
  function automatic logic is_reverse(dir_t a, dir_t b);
    return 2'(a) == (2'(b) ^ 2'd1);
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: synchronous direction FIFO, DEPTH entries (power of two),
// with registered count/full/empty flags and a synchronous flush.
module cmd_fifo
  import snake_cmd_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  dir_t             din_i,
  output dir_t             dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  dir_t             mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             full_q;
  logic             empty_q;

  assign cnt_d = cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);

  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_q] <= din_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push_i) wr_q <= wr_q + AW'(1);
      if (pop_i)  rd_q <= rd_q + AW'(1);
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == CNT_W'(DEPTH));
      empty_q <= (cnt_d == '0);
    end
  end

  assign dout_o  = mem_q[rd_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/snake_cmd_queue.sv
// snake_cmd_queue: key decode, repeat filter, WAIT/PLAY FSM and heading register.
// Define SNAKE_CMD_CASE_INSENSITIVE_EN to accept uppercase command keys too.
module snake_cmd_queue
  import snake_cmd_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CNT_W      = $clog2(DEPTH + 1),
  parameter int unsigned REPEAT_GAP = 1000000,
  parameter logic [1:0]  INIT_DIR   = 2'd3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  input  logic [7:0]       key_code,
  input  logic             tick,
  output logic [1:0]       dir,
  output logic [3:0]       dir_onehot,
  output logic             cmd_reset,
  output logic             cmd_start,
  output logic             playing,
  output logic [CNT_W-1:0] q_count,
  output logic             overflow
);

  localparam logic [31:0] GAP = 32'(REPEAT_GAP);
  localparam dir_t        INIT = dir_t'(INIT_DIR);

  state_t      state_q;
  dir_t        dir_q;
  dir_t        dir_d;
  logic [3:0]  oh_q;
  logic        rst_pulse_q;
  logic        start_pulse_q;
  logic        ovf_q;
  logic [31:0] rep_cnt_q;
  dir_t        last_dir_q;
  logic        last_vld_q;

  logic [7:0]  code;
  logic        is_dir;
  logic        is_r;
  logic        is_q;
  dir_t        key_dir;

  logic        rep_hit;
  logic        acc_dir;
  logic        do_r;
  logic        do_pop;
  logic        do_push;
  logic        full;
  logic        empty;
  dir_t        head;

  always_comb begin
    code = key_code;
`ifdef SNAKE_CMD_CASE_INSENSITIVE_EN
    if (key_code >= 8'h41 && key_code <= 8'h5A) begin
      code = key_code | 8'h20;
    end
`endif
    is_dir  = 1'b0;
    is_r    = 1'b0;
    is_q    = 1'b0;
    key_dir = DIR_UP;
    unique case (1'b1)
      code == KEY_UP:    begin is_dir = 1'b1; key_dir = DIR_UP;    end
      code == KEY_DOWN:  begin is_dir = 1'b1; key_dir = DIR_DOWN;  end
      code == KEY_LEFT:  begin is_dir = 1'b1; key_dir = DIR_LEFT;  end
      code == KEY_RIGHT: begin is_dir = 1'b1; key_dir = DIR_RIGHT; end
      code == KEY_RESET: is_r = 1'b1;
      code == KEY_START: is_q = 1'b1;
      default: ;
    endcase
  end

  assign rep_hit = last_vld_q && (last_dir_q == key_dir) && (rep_cnt_q < GAP);
  assign do_r    = key_valid && is_r;
  assign acc_dir = key_valid && is_dir && (state_q == ST_PLAY) && !rep_hit;
  assign do_pop  = tick && (state_q == ST_PLAY) && !empty && !do_r;
  // A full FIFO still takes a push when the same cycle pops.
  assign do_push = acc_dir && (!full || do_pop);

  always_comb begin
    dir_d = dir_q;
    if (do_r) begin
      dir_d = INIT;
    end else if (do_pop && !is_reverse(head, dir_q)) begin
      dir_d = head;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_WAIT;
      dir_q         <= INIT;
      oh_q          <= 4'd1 << INIT_DIR;
      rst_pulse_q   <= 1'b0;
      start_pulse_q <= 1'b0;
      ovf_q         <= 1'b0;
      rep_cnt_q     <= GAP;
      last_dir_q    <= DIR_UP;
      last_vld_q    <= 1'b0;
    end else begin
      dir_q         <= dir_d;
      oh_q          <= 4'd1 << dir_d;
      rst_pulse_q   <= do_r;
      start_pulse_q <= key_valid && is_q && (state_q == ST_WAIT);
      if (rep_cnt_q < GAP) rep_cnt_q <= rep_cnt_q + 32'd1;
      if (do_r) begin
        state_q    <= ST_WAIT;
        ovf_q      <= 1'b0;
        rep_cnt_q  <= GAP;
        last_vld_q <= 1'b0;
      end else begin
        if (key_valid && is_q && state_q == ST_WAIT) state_q <= ST_PLAY;
        if (acc_dir) begin
          last_dir_q <= key_dir;
          last_vld_q <= 1'b1;
          rep_cnt_q  <= '0;
        end
        if (acc_dir && full && !do_pop) ovf_q <= 1'b1;
      end
    end
  end

  cmd_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (do_r),
    .push_i  (do_push),
    .pop_i   (do_pop),
    .din_i   (key_dir),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (q_count)
  );

  assign dir        = dir_q;
  assign dir_onehot = oh_q;
  assign cmd_reset  = rst_pulse_q;
  assign cmd_start  = start_pulse_q;
  assign playing    = (state_q == ST_PLAY);
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_snake_cmd_queue.sv
// tb_snake_cmd_queue: directed plus random stimulus against a queue-based
// reference model; a monitor compares DUT outputs with scoreboard entries.
module tb_snake_cmd_queue;

  localparam int DEPTH = 4;
  localparam int GAP   = 8;
  localparam int INIT  = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_valid = 1'b0;
  logic [7:0] key_code = 8'h00;
  logic       tick = 1'b0;
  logic [1:0] dir;
  logic [3:0] dir_onehot;
  logic       cmd_reset;
  logic       cmd_start;
  logic       playing;
  logic [2:0] q_count;
  logic       overflow;

  always #5 clk = ~clk;

  snake_cmd_queue #(
    .DEPTH      (DEPTH),
    .REPEAT_GAP (GAP),
    .INIT_DIR   (2'(INIT))
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .tick       (tick),
    .dir        (dir),
    .dir_onehot (dir_onehot),
    .cmd_reset  (cmd_reset),
    .cmd_start  (cmd_start),
    .playing    (playing),
    .q_count    (q_count),
    .overflow   (overflow)
  );

  typedef struct {
    int dir;
    int oh;
    int rs;
    int st;
    int pl;
    int cnt;
    int ov;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  int   mq[$];
  int   mdir = INIT;
  bit   mplay = 1'b0;
  bit   movf = 1'b0;
  int   mlast = -1;
  int   mlast_t = 0;
  int   cyc = 0;
  int   opp[4] = '{1, 0, 3, 2};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic mreset();
    mq.delete();
    mdir  = INIT;
    mplay = 1'b0;
    movf  = 1'b0;
    mlast = -1;
  endtask

  task automatic step(input bit r_n, input bit kv, input logic [7:0] kc, input bit tk);
    exp_t       e;
    logic [7:0] c;
    int         d;
    int         h;
    bit         isd;
    bit         was_play;
    @(negedge clk);
    rst_n     = r_n;
    key_valid = kv;
    key_code  = kc;
    tick      = tk;
    cyc++;
    e.rs = 0;
    e.st = 0;
    c = kc;
`ifdef SNAKE_CMD_CASE_INSENSITIVE_EN
    if (c >= 8'h41 && c <= 8'h5A) c = c + 8'h20;
`endif
    isd = 1'b1;
    d   = 0;
    if (c == 8'h77) d = 0;
    else if (c == 8'h73) d = 1;
    else if (c == 8'h61) d = 2;
    else if (c == 8'h64) d = 3;
    else isd = 1'b0;
    if (!r_n) begin
      mreset();
    end else if (kv && c == 8'h72) begin
      mreset();
      e.rs = 1;
    end else begin
      was_play = mplay;
      if (tk && mplay && mq.size() > 0) begin
        h = mq.pop_front();
        if (h != opp[mdir]) mdir = h;
      end
      if (kv && c == 8'h71 && !mplay) begin
        mplay = 1'b1;
        e.st  = 1;
      end
      if (kv && isd && was_play && !(mlast == d && cyc - mlast_t <= GAP)) begin
        mlast   = d;
        mlast_t = cyc;
        if (mq.size() < DEPTH) mq.push_back(d);
        else movf = 1'b1;
      end
    end
    e.dir = mdir;
    e.oh  = 1 << mdir;
    e.pl  = int'(mplay);
    e.cnt = mq.size();
    e.ov  = int'(movf);
    sb.push_back(e);
  endtask

  task automatic key(input logic [7:0] kc, input bit tk);
    step(1'b1, 1'b1, kc, tk);
  endtask

  task automatic idle(input int n, input bit tk);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00, tk);
  endtask

  // Monitor: one scoreboard entry per cycle, sampled just after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("dir",        32'(dir),        32'(e.dir));
        chk("dir_onehot", 32'(dir_onehot), 32'(e.oh));
        chk("cmd_reset",  32'(cmd_reset),  32'(e.rs));
        chk("cmd_start",  32'(cmd_start),  32'(e.st));
        chk("playing",    32'(playing),    32'(e.pl));
        chk("q_count",    32'(q_count),    32'(e.cnt));
        chk("overflow",   32'(overflow),   32'(e.ov));
      end
    end
  end

  initial begin
    int n;
    logic [7:0] kc;
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    // 'd' in WAIT, then tick
    key(8'h64, 1'b0);
    idle(1, 1'b1);
    idle(1, 1'b0);
    // start, 'w', tick
    key(8'h71, 1'b0);
    idle(2, 1'b0);
    key(8'h77, 1'b0);
    idle(1, 1'b1);
    idle(2, 1'b0);
    // back to dir=3, reversal 'a' discarded
    key(8'h72, 1'b0);
    key(8'h71, 1'b0);
    key(8'h61, 1'b0);
    idle(1, 1'b1);
    idle(2, 1'b0);
    // repeat filter
    key(8'h77, 1'b0);
    idle(2, 1'b0);
    key(8'h77, 1'b0);
    idle(9, 1'b0);
    key(8'h77, 1'b0);
    idle(2, 1'b0);
    // fill, overflow, push+pop when full
    key(8'h72, 1'b0);
    key(8'h71, 1'b0);
    key(8'h77, 1'b0); idle(9, 1'b0);
    key(8'h73, 1'b0); idle(9, 1'b0);
    key(8'h77, 1'b0); idle(9, 1'b0);
    key(8'h73, 1'b0); idle(9, 1'b0);
    key(8'h61, 1'b0); idle(2, 1'b0);
    key(8'h64, 1'b1); idle(2, 1'b0);
    // 'r' plus tick with q_count=3
    idle(1, 1'b1);
    idle(1, 1'b0);
    key(8'h72, 1'b1);
    idle(2, 1'b0);
    // push into empty FIFO with tick
    key(8'h71, 1'b0);
    key(8'h61, 1'b1);
    idle(2, 1'b0);
    // random phase
    for (int i = 0; i < 3000; i++) begin
      n = $urandom_range(0, 39);
      case ($urandom_range(0, 3))
        0: kc = 8'h77;
        1: kc = 8'h73;
        2: kc = 8'h61;
        default: kc = 8'h64;
      endcase
      if (n >= 28 && n < 31) kc = 8'h71;
      else if (n == 31) kc = 8'h72;
      else if (n >= 32 && n < 34) kc = 8'h78;
      else if (n >= 34 && n < 36) kc = 8'h57 ^ 8'(($urandom_range(0, 1)) * 8'h04);
      else if (n == 36) kc = 8'h51;
      if ($urandom_range(0, 299) == 0) step(1'b0, 1'b0, 8'h00, 1'b0);
      else step(1'b1, $urandom_range(0, 2) == 0, kc, $urandom_range(0, 3) == 0);
    end
    idle(2, 1'b0);
    @(posedge clk);
    #2;
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
